gtx_frame_rx: RTL



---
 rtl/gtx_frame_rx_if.sv | 21 ++
 rtl/gtx_frame_rx.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/gtx_frame_rx_if.sv
// rtl/gtx_frame_rx_if.sv - GTX RX word stream in, framed payload and link status out
interface gtx_frame_rx_if #(
    parameter int DATA_WIDTH = 2
);
    logic [1:0]            ctrl_i;
    logic [15:0]           data_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  locked_o;
    logic [15:0]           err_cnt_o;

    modport master (
        output ctrl_i, data_i,
        input  data_o, valid_o, locked_o, err_cnt_o
    );

    modport slave (
        input  ctrl_i, data_i,
        output data_o, valid_o, locked_o, err_cnt_o
    );
endinterface

// File: rtl/gtx_frame_rx.sv
// rtl/gtx_frame_rx.sv - framed, checksummed GTX RX link receiver with lock hysteresis
module gtx_frame_rx #(
    parameter int                    DATA_WIDTH = 2,
    parameter int                    LOCK_CNT   = 4,
    parameter int                    UNLOCK_CNT = 3,
    parameter int                    TIMEOUT    = 1024,
    parameter logic [DATA_WIDTH-1:0] DEFAULT    = '0
) (
    input logic          clk_i,
    input logic          rst_n_i,
    gtx_frame_rx_if.slave rx
);
    localparam int WORDS = (DATA_WIDTH + 15) / 16;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_HUNT, S_DATA, S_CSUM} state_t;

    state_t                r_state, w_state_nxt;
    logic                  w_sof, w_ctrl_data, w_last_word, w_store;
    logic                  w_frame_good, w_frame_bad, w_frame_end, w_timeout, w_seq_err;
    logic [IW-1:0]         r_idx;
    logic [15:0]           r_sum;
    logic [7:0]            r_seq, r_prev_seq;
    logic [7:0]            r_good_cnt, r_bad_cnt, w_good_nxt, w_bad_nxt;
    logic [TW-1:0]         r_timer;
    logic                  r_locked, w_locked_nxt;
    logic [DATA_WIDTH-1:0] w_payload, r_data;
    logic                  r_valid;
    logic [15:0]           r_err_cnt;

    assign w_sof       = (rx.ctrl_i == 2'b01) && (rx.data_i[7:0] == 8'h3C);
    assign w_ctrl_data = (rx.ctrl_i == 2'b00);
    assign w_last_word = (r_idx == IW'(WORDS - 1));
    assign w_store     = (r_state == S_DATA) && w_ctrl_data;
    assign w_frame_end = w_frame_good || w_frame_bad;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= S_HUNT;
        else          r_state <= w_state_nxt;
    end

    // A K-word inside a frame aborts it; an SOF among them immediately opens the next frame.
    always_comb begin
        w_state_nxt  = r_state;
        w_frame_good = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            S_HUNT: if (w_sof) w_state_nxt = S_DATA;
            S_DATA: begin
                if (!w_ctrl_data) begin
                    w_frame_bad = 1'b1;
                    w_state_nxt = w_sof ? S_DATA : S_HUNT;
                end else if (w_last_word) begin
                    w_state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                w_state_nxt = S_HUNT;
                if (w_ctrl_data && (rx.data_i == r_sum)) begin
                    w_frame_good = 1'b1;
                end else begin
                    w_frame_bad = 1'b1;
                    if (w_sof) w_state_nxt = S_DATA;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_seq <= '0;
            r_sum <= '0;
            r_idx <= '0;
        end else if (w_sof) begin
            r_seq <= rx.data_i[15:8];
            r_sum <= '0;
            r_idx <= '0;
        end else if (w_store) begin
            r_sum <= r_sum + rx.data_i;
            r_idx <= w_last_word ? '0 : r_idx + IW'(1);
        end
    end

    // Only the payload bits that reach data_o are stored; upper bits of the last word are just summed.
    for (genvar i = 0; i < WORDS; i++) begin : g_word
        localparam int BW = ((DATA_WIDTH - 16 * i) > 16) ? 16 : (DATA_WIDTH - 16 * i);
        logic [BW-1:0] r_w;
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i)                          r_w <= '0;
            else if (w_store && r_idx == IW'(i))   r_w <= rx.data_i[BW-1:0];
        end
        assign w_payload[16*i +: BW] = r_w;
    end

    assign w_timeout = !w_frame_end && (r_timer == TW'(TIMEOUT - 1));
    assign w_seq_err = w_frame_good && r_locked && (r_seq != r_prev_seq + 8'd1);

    always_comb begin
        w_good_nxt   = r_good_cnt;
        w_bad_nxt    = r_bad_cnt;
        w_locked_nxt = r_locked;
        if (w_frame_good) begin
            w_good_nxt = (r_good_cnt == 8'(LOCK_CNT)) ? r_good_cnt : r_good_cnt + 8'd1;
            w_bad_nxt  = '0;
            if (w_good_nxt == 8'(LOCK_CNT)) w_locked_nxt = 1'b1;
        end else if (w_frame_bad) begin
            w_bad_nxt  = (r_bad_cnt == 8'(UNLOCK_CNT)) ? r_bad_cnt : r_bad_cnt + 8'd1;
            w_good_nxt = '0;
            if (w_bad_nxt == 8'(UNLOCK_CNT)) w_locked_nxt = 1'b0;
        end else if (w_timeout) begin
            w_good_nxt   = '0;
            w_bad_nxt    = '0;
            w_locked_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
            r_locked   <= 1'b0;
            r_timer    <= '0;
            r_prev_seq <= '0;
            r_err_cnt  <= '0;
            r_data     <= DEFAULT;
            r_valid    <= 1'b0;
        end else begin
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
            r_locked   <= w_locked_nxt;
            r_valid    <= 1'b0;
            if (w_frame_end)                    r_timer <= '0;
            else if (r_timer != TW'(TIMEOUT))   r_timer <= r_timer + TW'(1);
            if (w_frame_good)                   r_prev_seq <= r_seq;
            if ((w_frame_bad || w_seq_err) && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
            if (w_frame_good && w_locked_nxt) begin
                r_data  <= w_payload;
                r_valid <= 1'b1;
            end else if (!w_locked_nxt) begin
                r_data <= DEFAULT;
            end
        end
    end

    assign rx.data_o    = r_data;
    assign rx.valid_o   = r_valid;
    assign rx.locked_o  = r_locked;
    assign rx.err_cnt_o = r_err_cnt;
endmodule
